seven_seg_scan: RTL and testbench

- Parametrised multi-digit, time-multiplexed seven-segment display driver.
- Decodes full hex (0-F) per digit and drives one shared segment bus plus per-digit enables. Scans digits round-robin.
- Adds per-digit decimal point and blanking, an anti-ghosting blank interval, and frame-synchronous (tear-free) value update.
- Sits between the CPU/debug register block and the board's seven-segment pins.

---
 rtl/seven_seg_scan_if.sv | 24 ++
 rtl/seven_seg_scan.sv | 143 ++++++++++++++
 tb/tb_seven_seg_scan.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_if.sv
// Seven-segment scanner bus: captured display inputs from the register block, pin-level outputs.
// Pure signal bundle; no flow control, load is a single-cycle strobe.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load;
  logic [6:0]              segments_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;

  modport master (
    output value_in, dp_in, blank_in, load,
    input  segments_out, dp_out, digit_en, frame_done
  );

  modport slave (
    input  value_in, dp_in, blank_in, load,
    output segments_out, dp_out, digit_en, frame_done
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex seven-segment driver with blank interval and frame-synchronous update.
// Outputs registered, one cycle behind scan state; no backpressure, load is always accepted.
module seven_seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 8,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input logic             clk,
  input logic             reset,
  seven_seg_scan_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_OFF = {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_INV}};

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;
  localparam phase_t PH_RESET = (BLANK_CYCLES > 0) ? PH_BLANK : PH_DRIVE;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b0111111;
      4'h1: decode = 7'b0000110;
      4'h2: decode = 7'b1011011;
      4'h3: decode = 7'b1001111;
      4'h4: decode = 7'b1100110;
      4'h5: decode = 7'b1101101;
      4'h6: decode = 7'b1111101;
      4'h7: decode = 7'b0000111;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1101111;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b1111100;
      4'hC: decode = 7'b0111001;
      4'hD: decode = 7'b1011110;
      4'hE: decode = 7'b1111001;
      default: decode = 7'b1110001;
    endcase
  endfunction

  logic [CW-1:0]           cnt_q, cnt_nxt;
  logic [IW-1:0]           idx_q, idx_nxt;
  phase_t                  phase_q, phase_nxt;
  logic                    frame_wrap;
  logic [4*NUM_DIGITS-1:0] disp_val_q, pend_val_q;
  logic [NUM_DIGITS-1:0]   disp_dp_q, pend_dp_q;
  logic [NUM_DIGITS-1:0]   disp_blank_q, pend_blank_q;
  logic                    pend_vld_q;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    frame_done_q;

  always_comb begin
    frame_wrap = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    cnt_nxt    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_nxt    = idx_q;
    if (cnt_q == CNT_LAST)
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    // Phase register tracks the counter value it will hold next cycle.
    phase_nxt = (int'(cnt_nxt) < BLANK_CYCLES) ? PH_BLANK : PH_DRIVE;
    cur_nib   = disp_val_q[{idx_q, 2'b00} +: 4];
    cur_dp    = disp_dp_q[idx_q];
    cur_blank = disp_blank_q[idx_q];
    onehot         = '0;
    onehot[idx_q]  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      phase_q      <= PH_RESET;
      en_q         <= DIG_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_INV;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_nxt;
      idx_q        <= idx_nxt;
      phase_q      <= phase_nxt;
      frame_done_q <= frame_wrap;
      if (phase_q == PH_DRIVE) begin
        en_q <= onehot ^ DIG_OFF;
        if (cur_blank) begin
          seg_q <= SEG_OFF;
          dp_q  <= SEG_INV;
        end else begin
          seg_q <= decode(cur_nib) ^ SEG_OFF;
          dp_q  <= cur_dp ^ SEG_INV;
        end
      end else begin
        en_q  <= DIG_OFF;
        seg_q <= SEG_OFF;
        dp_q  <= SEG_INV;
      end
    end
  end

  // Display only changes on the frame-wrap edge; a load in that same cycle skips pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_vld_q   <= 1'b0;
    end else if (bus.load && frame_wrap) begin
      disp_val_q   <= bus.value_in;
      disp_dp_q    <= bus.dp_in;
      disp_blank_q <= bus.blank_in;
      pend_vld_q   <= 1'b0;
    end else if (frame_wrap && pend_vld_q) begin
      disp_val_q   <= pend_val_q;
      disp_dp_q    <= pend_dp_q;
      disp_blank_q <= pend_blank_q;
      pend_vld_q   <= 1'b0;
    end else if (bus.load) begin
      pend_val_q   <= bus.value_in;
      pend_dp_q    <= bus.dp_in;
      pend_blank_q <= bus.blank_in;
      pend_vld_q   <= 1'b1;
    end
  end

  assign bus.segments_out = seg_q;
  assign bus.dp_out       = dp_q;
  assign bus.digit_en     = en_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: three parameter sets share one clock and reset.
// Cycle k counts rising edges since the last reset release; outputs sampled 1ns after each edge.
module tb_seven_seg_scan;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_err;

  localparam logic [6:0] S0   = 7'b0111111;
  localparam logic [6:0] S1   = 7'b0000110;
  localparam logic [6:0] S3   = 7'b1001111;
  localparam logic [6:0] S5   = 7'b1101101;
  localparam logic [6:0] S7   = 7'b0000111;
  localparam logic [6:0] S8   = 7'b1111111;
  localparam logic [6:0] SA   = 7'b1110111;
  localparam logic [6:0] SF   = 7'b1110001;
  localparam logic [6:0] SOFF = 7'b0000000;

  seven_seg_scan_if #(.NUM_DIGITS(4)) if_a ();
  seven_seg_scan_if #(.NUM_DIGITS(4)) if_b ();
  seven_seg_scan_if #(.NUM_DIGITS(1)) if_c ();

  seven_seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(16), .BLANK_CYCLES(2),
                   .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  seven_seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(16), .BLANK_CYCLES(2),
                   .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));
  seven_seg_scan #(.NUM_DIGITS(1), .SCAN_DIV(2), .BLANK_CYCLES(0),
                   .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
    dut_c (.clk(clk), .reset(reset), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic       ld;
    logic [15:0] val;
    logic [3:0] dp;
    logic [3:0] en;
    logic [6:0] seg;
    logic       edp;
    logic       fd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int k, input logic ld, input logic [15:0] val, input logic [3:0] dp,
                     input logic [3:0] en, input logic [6:0] seg, input logic edp, input logic fd);
    vec_t v;
    v.k = k; v.ld = ld; v.val = val; v.dp = dp;
    v.en = en; v.seg = seg; v.edp = edp; v.fd = fd;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if_a.load = 1'b0;
    if_b.load = 1'b0;
    if_c.load = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] en, input logic [6:0] seg,
                       input logic dp, input logic fd);
    chk($sformatf("%s a_en@%0d", tag, cyc), 32'(if_a.digit_en), 32'(en));
    chk($sformatf("%s a_seg@%0d", tag, cyc), 32'(if_a.segments_out), 32'(seg));
    chk($sformatf("%s a_dp@%0d", tag, cyc), 32'(if_a.dp_out), 32'(dp));
    chk($sformatf("%s a_fd@%0d", tag, cyc), 32'(if_a.frame_done), 32'(fd));
  endtask

  task automatic chk_b(input logic [3:0] en, input logic [6:0] seg, input logic dp);
    chk($sformatf("b_en@%0d", cyc), 32'(if_b.digit_en), 32'(en));
    chk($sformatf("b_seg@%0d", cyc), 32'(if_b.segments_out), 32'(seg));
    chk($sformatf("b_dp@%0d", cyc), 32'(if_b.dp_out), 32'(dp));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    reset = 1'b1;
    if_a.value_in = '0; if_a.dp_in = '0; if_a.blank_in = '0; if_a.load = 1'b0;
    if_b.value_in = '0; if_b.dp_in = '0; if_b.blank_in = '0; if_b.load = 1'b0;
    if_c.value_in = '0; if_c.dp_in = '0; if_c.blank_in = '0; if_c.load = 1'b0;

    // Frame-relative cycle: output of digit d, slot offset o in frame f appears at 64f+16d+o+1.
    add(1,   0, 16'h0,    4'h0,    4'b0000, SOFF, 0, 0);
    add(2,   0, 16'h0,    4'h0,    4'b0000, SOFF, 0, 0);
    add(3,   0, 16'h0,    4'h0,    4'b0001, S0,   0, 0);
    add(16,  0, 16'h0,    4'h0,    4'b0001, S0,   0, 0);
    add(17,  0, 16'h0,    4'h0,    4'b0000, SOFF, 0, 0);
    add(19,  0, 16'h0,    4'h0,    4'b0010, S0,   0, 0);
    add(64,  0, 16'h0,    4'h0,    4'b1000, S0,   0, 1);
    add(65,  0, 16'h0,    4'h0,    4'b0000, SOFF, 0, 0);
    add(67,  0, 16'h0,    4'h0,    4'b0001, S0,   0, 0);
    add(70,  1, 16'h1A3F, 4'b0100, 4'b0001, S0,   0, 0);
    add(99,  0, 16'h0,    4'h0,    4'b0100, S0,   0, 0);
    add(131, 0, 16'h0,    4'h0,    4'b0001, SF,   0, 0);
    add(144, 0, 16'h0,    4'h0,    4'b0001, SF,   0, 0);
    add(145, 0, 16'h0,    4'h0,    4'b0000, SOFF, 0, 0);
    add(146, 0, 16'h0,    4'h0,    4'b0000, SOFF, 0, 0);
    add(147, 0, 16'h0,    4'h0,    4'b0010, S3,   0, 0);
    add(150, 1, 16'h8888, 4'h0,    4'b0010, S3,   0, 0);
    add(163, 0, 16'h0,    4'h0,    4'b0100, SA,   1, 0);
    add(176, 0, 16'h0,    4'h0,    4'b0100, SA,   1, 0);
    add(179, 0, 16'h0,    4'h0,    4'b1000, S1,   0, 0);
    add(192, 0, 16'h0,    4'h0,    4'b1000, S1,   0, 1);
    add(195, 0, 16'h0,    4'h0,    4'b0001, S8,   0, 0);
    add(214, 1, 16'h0000, 4'h0,    4'b0010, S8,   0, 0);
    add(227, 0, 16'h0,    4'h0,    4'b0100, S8,   0, 0);
    add(243, 0, 16'h0,    4'h0,    4'b1000, S8,   0, 0);
    add(262, 0, 16'h0,    4'h0,    4'b0001, S0,   0, 0);
    add(266, 1, 16'h2222, 4'h0,    4'b0001, S0,   0, 0);
    add(278, 0, 16'h0,    4'h0,    4'b0010, S0,   0, 0);
    add(294, 0, 16'h0,    4'h0,    4'b0100, S0,   0, 0);
    add(310, 0, 16'h0,    4'h0,    4'b1000, S0,   0, 0);
    add(319, 1, 16'h5555, 4'h0,    4'b1000, S0,   0, 0);
    add(320, 0, 16'h0,    4'h0,    4'b1000, S0,   0, 1);
    add(326, 0, 16'h0,    4'h0,    4'b0001, S5,   0, 0);
    add(342, 0, 16'h0,    4'h0,    4'b0010, S5,   0, 0);
    add(358, 0, 16'h0,    4'h0,    4'b0100, S5,   0, 0);
    add(374, 0, 16'h0,    4'h0,    4'b1000, S5,   0, 0);
    add(390, 0, 16'h0,    4'h0,    4'b0001, S5,   0, 0);
    add(392, 1, 16'h3333, 4'h0,    4'b0001, S5,   0, 0);
    add(400, 1, 16'h7777, 4'h0,    4'b0001, S5,   0, 0);
    add(406, 0, 16'h0,    4'h0,    4'b0010, S5,   0, 0);
    add(454, 0, 16'h0,    4'h0,    4'b0001, S7,   0, 0);
    add(470, 0, 16'h0,    4'h0,    4'b0010, S7,   0, 0);
    add(486, 0, 16'h0,    4'h0,    4'b0100, S7,   0, 0);
    add(502, 0, 16'h0,    4'h0,    4'b1000, S7,   0, 0);

    // Reset levels on all three instances.
    repeat (3) @(posedge clk);
    #1;
    chk_a("rst", 4'b0000, SOFF, 1'b0, 1'b0);
    chk_b(4'b1111, 7'b1111111, 1'b1);
    chk("c_en_rst", 32'(if_c.digit_en), 32'd0);
    chk("c_fd_rst", 32'(if_c.frame_done), 32'd0);

    // Run into DRIVE with a pending load, then reset asynchronously mid-cycle.
    reset = 1'b0;
    cyc   = 0;
    while (cyc < 4) tick();
    if_a.value_in = 16'h8888;
    if_a.load     = 1'b1;
    tick();
    chk_a("pre", 4'b0001, S0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_a("async", 4'b0000, SOFF, 1'b0, 1'b0);
    chk("b_en_async", 32'(if_b.digit_en), 32'b1111);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    if_b.value_in = 16'h8888;
    if_b.dp_in    = 4'b1011;
    if_b.blank_in = 4'b1010;
    if_b.load     = 1'b1;

    foreach (vq[i]) begin
      while (cyc < vq[i].k) tick();
      chk_a("vec", vq[i].en, vq[i].seg, vq[i].edp, vq[i].fd);
      if (vq[i].ld) begin
        if_a.value_in = vq[i].val;
        if_a.dp_in    = vq[i].dp;
        if_a.load     = 1'b1;
      end
    end

    // Active-low instance with blanked digits 1 and 3, frame 8.
    while (cyc < 518) tick();
    chk_b(4'b1110, 7'b0000000, 1'b0);
    while (cyc < 529) tick();
    chk_b(4'b1111, 7'b1111111, 1'b1);
    while (cyc < 534) tick();
    chk_b(4'b1101, 7'b1111111, 1'b1);
    while (cyc < 550) tick();
    chk_b(4'b1011, 7'b0000000, 1'b1);
    while (cyc < 566) tick();
    chk_b(4'b0111, 7'b1111111, 1'b1);

    // Single digit, two-cycle slot, no blanking: frame_done on every even cycle.
    for (int n = 0; n < 6; n++) begin
      tick();
      chk($sformatf("c_en@%0d", cyc), 32'(if_c.digit_en), 32'd1);
      chk($sformatf("c_seg@%0d", cyc), 32'(if_c.segments_out), 32'(S0));
      chk($sformatf("c_fd@%0d", cyc), 32'(if_c.frame_done), 32'((cyc % 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
